// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and default width.
// Imported by the RTL and by the testbench so both agree on the encoding.
package serial_adder_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_gate.sv
// Single-bit full adder built from plain gate expressions; the only arithmetic
// element of the serial adder datapath.
module full_adder_gate (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  logic p;

  assign p    = a_i ^ b_i;
  assign s_o  = p ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & p);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder_gate, LSB first, registered carry.
// Optional macro SERIAL_ADDER_OVF_EN adds a signed-overflow output ovf.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [WIDTH-1:0] shs_q, shs_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_s, fa_co;

  full_adder_gate u_fa (
    .a_i  (sha_q[0]),
    .b_i  (shb_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    shs_d   = shs_q;
    carry_d = carry_q;
    count_d = count_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sha_d   = a;
          shb_d   = b;
          carry_d = cin;
          count_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        shs_d   = {fa_s, shs_q[WIDTH-1:1]};
        carry_d = fa_co;
        sha_d   = sha_q >> 1;
        shb_d   = shb_q >> 1;
        count_d = count_q + CW'(1);
        // Final bit: publish the result on the same edge the last sum bit lands.
        if (count_q == LAST) begin
          state_d = ST_DONE;
          sum_d   = {fa_s, shs_q[WIDTH-1:1]};
          cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ fa_co;
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      shs_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      shs_q   <= shs_d;
      carry_q <= carry_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8): vector table plus hand-written
// sequences for held start, mid-run reset and result hold.
module tb_serial_adder_ctrl;
  import serial_adder_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf   (ovf),
`endif
    .cout  (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vc;
    logic [7:0] es;
    logic       eco;
    logic       eov;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Drive operands and a one-cycle start; returns just after the accepting edge.
  task automatic launch(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    @(negedge clk);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges until done (bounded), and busy cycles seen before it.
  task automatic wait_done(output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (busy) busy_n++;
    end
  endtask

  int lat, bn, dn;
  logic [7:0] prev_sum;
  logic       prev_cout;

  initial begin
    tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[5] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0};

    // Reset, then idle with outputs quiet
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_sum",  32'(sum),  32'h00);
      check("idle_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      check("idle_ovf",  32'(ovf),  32'd0);
`endif
    end

    for (int i = 0; i < 6; i++) begin
      launch(tbl[i].va, tbl[i].vb, tbl[i].vc);
      wait_done(lat, bn);
      $display("op %0d: a=0x%02h b=0x%02h cin=%0d -> sum=0x%02h cout=%0d lat=%0d busy=%0d",
               i, tbl[i].va, tbl[i].vb, tbl[i].vc, sum, cout, lat, bn);
      check("op_latency", 32'(lat), 32'd9);
      check("op_busy_cycles", 32'(bn), 32'd8);
      check("op_sum", 32'(sum), 32'(tbl[i].es));
      check("op_cout", 32'(cout), 32'(tbl[i].eco));
`ifdef SERIAL_ADDER_OVF_EN
      check("op_ovf", 32'(ovf), 32'(tbl[i].eov));
`endif
      @(negedge clk);
      check("op_done_pulse", 32'(done), 32'd0);
      check("op_sum_hold", 32'(sum), 32'(tbl[i].es));
    end
    prev_sum  = tbl[5].es;
    prev_cout = tbl[5].eco;

    // start held through RUN with operand change: ignored, single done
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 a = 8'hFF;
    dn = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 2) begin
        check("hold_sum_during_run", 32'(sum), 32'(prev_sum));
        check("hold_cout_during_run", 32'(cout), 32'(prev_cout));
      end
      if (i == 5) start = 1'b0;
      if (done) begin
        dn++;
        check("held_start_sum", 32'(sum), 32'h46);
        check("held_start_cout", 32'(cout), 32'd0);
      end
    end
    $display("held start: done pulses=%0d sum=0x%02h", dn, sum);
    check("held_start_done_count", 32'(dn), 32'd1);

    launch(8'h21, 8'h10, 1'b0);
    wait_done(lat, bn);
    $display("after held start: sum=0x%02h lat=%0d", sum, lat);
    check("after_hold_latency", 32'(lat), 32'd9);
    check("after_hold_sum", 32'(sum), 32'h31);

    // Mid-run reset aborts
    launch(8'hAA, 8'h55, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    $display("mid-run reset: busy=%0d done=%0d sum=0x%02h cout=%0d", busy, done, sum, cout);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'h00);
    check("rst_cout", 32'(cout), 32'd0);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dn++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("rst_no_done", 32'(dn), 32'd0);
    check("rst_sum_after", 32'(sum), 32'h00);

    launch(8'h01, 8'h01, 1'b0);
    wait_done(lat, bn);
    $display("after reset: sum=0x%02h cout=%0d lat=%0d", sum, cout, lat);
    check("post_rst_latency", 32'(lat), 32'd9);
    check("post_rst_sum", 32'(sum), 32'h02);
    check("post_rst_cout", 32'(cout), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
